studio2_keypad_io: RTL and testbench

//  I/O-port responder on the CPU side bus: answers the CPU's OUT/INP strobes and drives its EF flags and beeper.

---
 rtl/studio2_keypad_io.sv | 122 ++++++++++++
 tb/tb_studio2_keypad_io.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/studio2_keypad_io.sv
// Keypad/audio I/O responder for the 1802 side bus: select latch on OUT 2, status on INP 1,
// two debounced 16-key hex pads presented on EF3/EF4, and a Q-gated square-wave beeper.
module studio2_keypad_io #(
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int TONE_DIV        = 1024
) (
  input  logic        clock,
  input  logic        resetq,
  input  logic [2:0]  io_n,
  input  logic        io_out,
  input  logic        io_inp,
  input  logic [7:0]  io_dout,
  output logic [7:0]  io_din,
  input  logic        q_in,
  input  logic [15:0] keys1,
  input  logic [15:0] keys2,
  output logic [3:0]  ef,
  output logic        beep
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TN_W = $clog2(TONE_DIV);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [TN_W-1:0] TN_LAST = TN_W'(TONE_DIV - 1);
  localparam logic [TN_W-1:0] TN_ONE  = TN_W'(1);

  // Pad 0 is keys1 (EF3), pad 1 is keys2 (EF4).
  logic [1:0][15:0] keys_raw;

  logic [1:0][15:0]     meta_q,   meta_d;
  logic [1:0][15:0]     sync_q,   sync_d;
  logic [1:0][15:0]     cand_q,   cand_d;
  logic [1:0][15:0]     stable_q, stable_d;
  logic [1:0][DB_W-1:0] cnt_q,    cnt_d;

  logic [3:0]      sel_q,  sel_d;
  logic [TN_W-1:0] tcnt_q, tcnt_d;
  logic            beep_q, beep_d;

  logic unused_dout_hi;

  assign keys_raw[0]    = keys1;
  assign keys_raw[1]    = keys2;
  assign unused_dout_hi = ^io_dout[7:4];

  always_comb begin
    meta_d   = keys_raw;
    sync_d   = meta_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // A candidate vector is committed only after it has held for the full count;
    // any change in between restarts the count, so no intermediate vector escapes.
    for (int p = 0; p < 2; p++) begin
      if (sync_q[p] != cand_q[p]) begin
        cand_d[p] = sync_q[p];
        cnt_d[p]  = '0;
      end else if (cnt_q[p] == DB_LAST) begin
        stable_d[p] = cand_q[p];
      end else begin
        cnt_d[p] = cnt_q[p] + DB_ONE;
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (io_out && (io_n == 3'd2)) begin
      sel_d = io_dout[3:0];
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    beep_d = beep_q;
    if (!q_in) begin
      tcnt_d = '0;
      beep_d = 1'b0;
    end else if (tcnt_q == TN_LAST) begin
      tcnt_d = '0;
      beep_d = ~beep_q;
    end else begin
      tcnt_d = tcnt_q + TN_ONE;
    end
  end

  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      tcnt_q   <= '0;
      beep_q   <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      tcnt_q   <= tcnt_d;
      beep_q   <= beep_d;
    end
  end

  // INP data must be valid in the strobe clock itself, so it is purely combinational.
  always_comb begin
    io_din = 8'hFF;
    if (io_inp && (io_n == 3'd1)) begin
      io_din = {|stable_q[1], |stable_q[0], 2'b00, sel_q};
    end
  end

  assign ef   = {stable_q[1][sel_q], stable_q[0][sel_q], 2'b00};
  assign beep = beep_q;

endmodule

// File: tb/tb_studio2_keypad_io.sv
// Directed bench for studio2_keypad_io with DEBOUNCE_CYCLES=4, TONE_DIV=3.
module tb_studio2_keypad_io;

  logic        clock = 1'b0;
  logic        resetq;
  logic [2:0]  io_n;
  logic        io_out;
  logic        io_inp;
  logic [7:0]  io_dout;
  logic [7:0]  io_din;
  logic        q_in;
  logic [15:0] keys1;
  logic [15:0] keys2;
  logic [3:0]  ef;
  logic        beep;

  int n_tests = 0;
  int n_fail  = 0;

  studio2_keypad_io #(
    .DEBOUNCE_CYCLES(4),
    .TONE_DIV(3)
  ) dut (
    .clock  (clock),
    .resetq (resetq),
    .io_n   (io_n),
    .io_out (io_out),
    .io_inp (io_inp),
    .io_dout(io_dout),
    .io_din (io_din),
    .q_in   (q_in),
    .keys1  (keys1),
    .keys2  (keys2),
    .ef     (ef),
    .beep   (beep)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic out_strobe(input logic [2:0] port, input logic [7:0] data);
    io_out  = 1'b1;
    io_n    = port;
    io_dout = data;
    tick(1);
    io_out  = 1'b0;
    io_n    = 3'd0;
    io_dout = 8'h00;
  endtask

  task automatic test_reset;
    resetq = 1'b0;
    keys1  = 16'hFFFF;
    keys2  = 16'h0000;
    q_in   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_tests++;
      if (ef !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ef cyc %0d: got %b want 0000", i, ef);
      end
      n_tests++;
      if (beep !== 1'b0) begin
        n_fail++; $display("FAIL reset_beep cyc %0d: got %b want 0", i, beep);
      end
      n_tests++;
      if (io_din !== 8'hFF) begin
        n_fail++; $display("FAIL reset_din cyc %0d: got %h want FF", i, io_din);
      end
    end
    resetq = 1'b1;
    q_in   = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      n_tests++;
      if (ef[2] !== (k == 7)) begin
        n_fail++; $display("FAIL reset_release_ef2 edge %0d: got %b want %b", k, ef[2], (k == 7));
      end
    end
  endtask

  task automatic test_select;
    keys1 = 16'h0020;
    tick(10);
    n_tests++;
    if (ef !== 4'b0000) begin
      n_fail++; $display("FAIL select_pre: got %b want 0000", ef);
    end
    io_out = 1'b1; io_n = 3'd2; io_dout = 8'hA5;
    #1;
    n_tests++;
    if (ef !== 4'b0000) begin
      n_fail++; $display("FAIL select_before_edge: got %b want 0000", ef);
    end
    tick(1);
    io_out = 1'b0; io_n = 3'd0; io_dout = 8'h00;
    n_tests++;
    if (ef !== 4'b0100) begin
      n_fail++; $display("FAIL select_a5: got %b want 0100", ef);
    end
    out_strobe(3'd2, 8'h03);
    n_tests++;
    if (ef !== 4'b0000) begin
      n_fail++; $display("FAIL select_03: got %b want 0000", ef);
    end
    out_strobe(3'd2, 8'hA5);
    n_tests++;
    if (ef !== 4'b0100) begin
      n_fail++; $display("FAIL select_restore: got %b want 0100", ef);
    end
  endtask

  task automatic test_port_decode;
    out_strobe(3'd3, 8'h0C);
    n_tests++;
    if (ef !== 4'b0100) begin
      n_fail++; $display("FAIL decode_out3: got %b want 0100", ef);
    end
    io_inp = 1'b1; io_n = 3'd1;
    #1;
    n_tests++;
    if (io_din !== 8'h45) begin
      n_fail++; $display("FAIL decode_inp1: got %h want 45", io_din);
    end
    for (int p = 0; p < 8; p++) begin
      if (p != 1) begin
        io_n = p[2:0];
        #1;
        n_tests++;
        if (io_din !== 8'hFF) begin
          n_fail++; $display("FAIL decode_inp_port%0d: got %h want FF", p, io_din);
        end
      end
    end
    io_inp = 1'b0; io_n = 3'd1;
    #1;
    n_tests++;
    if (io_din !== 8'hFF) begin
      n_fail++; $display("FAIL decode_noinp: got %h want FF", io_din);
    end
    io_n = 3'd0;
    tick(1);
  endtask

  task automatic test_bounce;
    out_strobe(3'd2, 8'h07);
    for (int i = 0; i < 10; i++) begin
      keys2[7] = ~keys2[7];
      for (int j = 0; j < 2; j++) begin
        tick(1);
        n_tests++;
        if (ef[3] !== 1'b0) begin
          n_fail++; $display("FAIL bounce_hold t%0d: got %b want 0", 2 * i + j, ef[3]);
        end
      end
    end
    keys2[7] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      n_tests++;
      if (ef[3] !== (k == 7)) begin
        n_fail++; $display("FAIL bounce_settle edge %0d: got %b want %b", k, ef[3], (k == 7));
      end
    end
    n_tests++;
    if (ef !== 4'b1000) begin
      n_fail++; $display("FAIL bounce_ef: got %b want 1000", ef);
    end
    io_inp = 1'b1; io_n = 3'd1;
    #1;
    n_tests++;
    if (io_din !== 8'hC7) begin
      n_fail++; $display("FAIL bounce_status: got %h want C7", io_din);
    end
    io_inp = 1'b0; io_n = 3'd0;
    tick(1);
  endtask

  task automatic test_tone;
    q_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      n_tests++;
      if (beep !== ((k / 3) % 2 == 1)) begin
        n_fail++; $display("FAIL tone_run edge %0d: got %b want %b", k, beep, ((k / 3) % 2 == 1));
      end
    end
    q_in = 1'b0;
    tick(1);
    q_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      n_tests++;
      if (beep !== ((k / 3) % 2 == 1)) begin
        n_fail++; $display("FAIL tone_short edge %0d: got %b want %b", k, beep, ((k / 3) % 2 == 1));
      end
    end
    q_in = 1'b0;
    tick(1);
    n_tests++;
    if (beep !== 1'b0) begin
      n_fail++; $display("FAIL tone_silence: got %b want 0", beep);
    end
    q_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_tests++;
      if (beep !== ((k / 3) % 2 == 1)) begin
        n_fail++; $display("FAIL tone_restart edge %0d: got %b want %b", k, beep, ((k / 3) % 2 == 1));
      end
    end
    q_in = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid;
    keys1 = 16'h0001;
    q_in  = 1'b1;
    tick(4);
    n_tests++;
    if (beep !== 1'b1 || ef !== 4'b1000) begin
      n_fail++; $display("FAIL midrst_pre: got beep=%b ef=%b want beep=1 ef=1000", beep, ef);
    end
    resetq = 1'b0;
    #1;
    n_tests++;
    if (ef !== 4'b0000 || beep !== 1'b0 || io_din !== 8'hFF) begin
      n_fail++; $display("FAIL midrst_now: got ef=%b beep=%b din=%h want 0000/0/FF", ef, beep, io_din);
    end
    io_inp = 1'b1; io_n = 3'd1;
    #1;
    n_tests++;
    if (io_din !== 8'h00) begin
      n_fail++; $display("FAIL midrst_status: got %h want 00", io_din);
    end
    io_inp = 1'b0; io_n = 3'd0;
    tick(2);
    n_tests++;
    if (ef !== 4'b0000 || beep !== 1'b0) begin
      n_fail++; $display("FAIL midrst_held: got ef=%b beep=%b want 0000/0", ef, beep);
    end
    resetq = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      n_tests++;
      if (ef !== ((k == 7) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("FAIL midrst_ef edge %0d: got %b want %b", k, ef, ((k == 7) ? 4'b0100 : 4'b0000));
      end
      n_tests++;
      if (beep !== ((k / 3) % 2 == 1)) begin
        n_fail++; $display("FAIL midrst_beep edge %0d: got %b want %b", k, beep, ((k / 3) % 2 == 1));
      end
    end
    q_in = 1'b0;
  endtask

  initial begin
    resetq  = 1'b0;
    io_n    = 3'd0;
    io_out  = 1'b0;
    io_inp  = 1'b0;
    io_dout = 8'h00;
    q_in    = 1'b0;
    keys1   = 16'h0000;
    keys2   = 16'h0000;
    test_reset;
    test_select;
    test_port_decode;
    test_bounce;
    test_tone;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
